// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants and stage occupancy encoding
package cpu_pkg;
    localparam int INSTR_W_DEF = 32;
    localparam int PC_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL1, ST_FULL2} occ_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter, adds 0..2 per cycle and sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W:0] sum;
    assign sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else cnt <= clr ? '0 : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer, flush and perf counters
module pipe_stage_skid
    import cpu_pkg::*;
#(
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter int                 PC_W      = PC_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(cpu_pkg::NOP_INSTR),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);
    occ_e               state;
    logic [INSTR_W-1:0] main_instr, skid_instr;
    logic [PC_W-1:0]    main_pc, skid_pc;
    logic               in_x, out_x;
    logic [1:0]         flush_inc, stall_inc;

    assign out_valid = state != ST_EMPTY;
    assign in_ready  = state != ST_FULL2;
    assign in_x      = in_valid & in_ready;
    assign out_x     = out_valid & out_ready;
    assign out_instr = out_valid ? main_instr : NOP_INSTR;
    assign out_pc    = out_valid ? main_pc : '0;

    // entries killed by flush exclude the head if downstream takes it the same cycle
    always_comb begin
        flush_inc = '0;
        stall_inc = {1'b0, out_valid & ~out_ready};
        if (flush)
            flush_inc = (state == ST_FULL2 ? 2'd2 : state == ST_FULL1 ? 2'd1 : 2'd0) - {1'b0, out_x};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_EMPTY;
            main_instr <= '0;
            main_pc    <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (in_x) begin
                    main_instr <= in_instr;
                    main_pc    <= in_pc;
                    state      <= ST_FULL1;
                end
                ST_FULL1: if (in_x && !out_ready) begin
                    skid_instr <= in_instr;
                    skid_pc    <= in_pc;
                    state      <= ST_FULL2;
                end else if (in_x) begin
                    main_instr <= in_instr;
                    main_pc    <= in_pc;
                end else if (out_ready) begin
                    state <= ST_EMPTY;
                end
                ST_FULL2: if (out_ready) begin
                    main_instr <= skid_instr;
                    main_pc    <= skid_pc;
                    state      <= ST_FULL1;
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk(clk), .reset_n(reset_n), .clr(1'b0), .inc(stall_inc), .cnt(stall_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flush (
        .clk(clk), .reset_n(reset_n), .clr(1'b0), .inc(flush_inc), .cnt(flush_cnt)
    );
endmodule
